// File: rtl/div_seq.sv
// Multi-cycle radix-2 restoring divider (DIV/DIVU) for the EX stage; result = {remainder, quotient}.
// Optional build macro DIV_EARLY_OUT_EN: finish in one extra cycle when |divisor| > |dividend|.
module div_seq #(
  parameter int DW = 32,
  parameter int CW = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            signed_div_i,
  input  logic [DW-1:0]   opdata1_i,
  input  logic [DW-1:0]   opdata2_i,
  input  logic            start_i,
  input  logic            annul_i,
  output logic [2*DW-1:0] result_o,
  output logic            ready_o
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_BYZERO = 3'd1;
  localparam logic [2:0] S_ON     = 3'd2;
  localparam logic [2:0] S_END    = 3'd3;
`ifdef DIV_EARLY_OUT_EN
  localparam logic [2:0] S_EARLY  = 3'd4;
`endif

  logic [2:0]      state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [DW-1:0]   rem_q, rem_d;
  logic [DW-1:0]   dvd_q, dvd_d;
  logic [DW-1:0]   dsr_q, dsr_d;
  logic            sgn_q, sgn_d;
  logic            s1_q, s1_d;
  logic            s2_q, s2_d;
  logic [2*DW-1:0] result_q, result_d;
  logic            ready_q, ready_d;

  logic [DW-1:0]   abs1, abs2;
  logic [DW:0]     shifted, diff;
  logic            trial_ge;
  logic [DW-1:0]   rem_nx, quo_nx;
  logic            neg_q, neg_r;

  always_comb begin
    abs1 = (signed_div_i && opdata1_i[DW-1]) ? -opdata1_i : opdata1_i;
    abs2 = (signed_div_i && opdata2_i[DW-1]) ? -opdata2_i : opdata2_i;

    // The dividend register doubles as the quotient shift register.
    shifted  = {rem_q, dvd_q[DW-1]};
    diff     = shifted - {1'b0, dsr_q};
    trial_ge = (shifted >= {1'b0, dsr_q});
    rem_nx   = trial_ge ? diff[DW-1:0] : shifted[DW-1:0];
    quo_nx   = {dvd_q[DW-2:0], trial_ge};

    neg_q = sgn_q & (s1_q ^ s2_q);
    neg_r = sgn_q & s1_q;

    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    dvd_d    = dvd_q;
    dsr_d    = dsr_q;
    sgn_d    = sgn_q;
    s1_d     = s1_q;
    s2_d     = s2_q;
    result_d = result_q;
    ready_d  = ready_q;

    case (state_q)
      S_IDLE: begin
        if (start_i && !annul_i) begin
          if (opdata2_i == '0) begin
            state_d = S_BYZERO;
          end else begin
            dvd_d = abs1;
            dsr_d = abs2;
            sgn_d = signed_div_i;
            s1_d  = opdata1_i[DW-1];
            s2_d  = opdata2_i[DW-1];
            cnt_d = '0;
            rem_d = '0;
`ifdef DIV_EARLY_OUT_EN
            state_d = (abs2 > abs1) ? S_EARLY : S_ON;
`else
            state_d = S_ON;
`endif
          end
        end
      end
      S_BYZERO: begin
        if (!start_i) begin
          state_d = S_IDLE;
        end else begin
          state_d  = S_END;
          result_d = '0;
          ready_d  = 1'b1;
        end
      end
      S_ON: begin
        if (!start_i) begin
          state_d  = S_IDLE;
          cnt_d    = '0;
          result_d = '0;
          ready_d  = 1'b0;
        end else begin
          rem_d = rem_nx;
          dvd_d = quo_nx;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(DW-1)) begin
            state_d  = S_END;
            result_d = {(neg_r ? -rem_nx : rem_nx), (neg_q ? -quo_nx : quo_nx)};
            ready_d  = 1'b1;
          end
        end
      end
`ifdef DIV_EARLY_OUT_EN
      S_EARLY: begin
        if (!start_i) begin
          state_d = S_IDLE;
        end else begin
          // Re-applying the dividend sign to its magnitude recovers the original opdata1_i.
          state_d  = S_END;
          result_d = {(neg_r ? -dvd_q : dvd_q), {DW{1'b0}}};
          ready_d  = 1'b1;
        end
      end
`endif
      S_END: begin
        if (!start_i) begin
          state_d  = S_IDLE;
          result_d = '0;
          ready_d  = 1'b0;
        end
      end
      default: begin
        state_d  = S_IDLE;
        result_d = '0;
        ready_d  = 1'b0;
      end
    endcase

    if (annul_i) begin
      state_d  = S_IDLE;
      cnt_d    = '0;
      result_d = '0;
      ready_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      rem_q    <= '0;
      dvd_q    <= '0;
      dsr_q    <= '0;
      sgn_q    <= 1'b0;
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      result_q <= '0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      dvd_q    <= dvd_d;
      dsr_q    <= dsr_d;
      sgn_q    <= sgn_d;
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      result_q <= result_d;
      ready_q  <= ready_d;
    end
  end

  assign result_o = result_q;
  assign ready_o  = ready_q;

endmodule

// File: tb/tb_div_seq.sv
// Directed self-checking bench for div_seq; latency of small-quotient cases follows DIV_EARLY_OUT_EN.
module tb_div_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        signed_div;
  logic [31:0] op1, op2;
  logic        start, annul;
  logic [63:0] result;
  logic        ready;

  int checks = 0;
  int errors = 0;
  logic seen;

`ifdef DIV_EARLY_OUT_EN
  localparam int SMALL_LAT = 2;
`else
  localparam int SMALL_LAT = 33;
`endif

  div_seq #(.DW(32), .CW(6)) dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div),
    .opdata1_i    (op1),
    .opdata2_i    (op2),
    .start_i      (start),
    .annul_i      (annul),
    .result_o     (result),
    .ready_o      (ready)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Request issued in the current cycle N; result expected in cycle N+lat, held one more cycle.
  task automatic do_div(input logic sg, input logic [31:0] a, input logic [31:0] b,
                        input int lat, input logic [63:0] exp, input string tag);
    signed_div = sg;
    op1 = a;
    op2 = b;
    start = 1'b1;
    tick();
    op1 = $urandom;
    op2 = $urandom;
    for (int i = 2; i < lat; i++) tick();
    chk({tag, "_early"}, {63'd0, ready}, 64'd0);
    tick();
    chk({tag, "_ready"}, {63'd0, ready}, 64'd1);
    chk({tag, "_result"}, result, exp);
    tick();
    chk({tag, "_hold_ready"}, {63'd0, ready}, 64'd1);
    chk({tag, "_hold_result"}, result, exp);
    start = 1'b0;
    tick();
    chk({tag, "_drop_ready"}, {63'd0, ready}, 64'd0);
    chk({tag, "_drop_result"}, result, 64'd0);
  endtask

  initial begin
    rst = 1'b1;
    signed_div = 1'b0;
    op1 = '0;
    op2 = '0;
    start = 1'b0;
    annul = 1'b0;
    tick();
    tick();
    chk("reset_ready", {63'd0, ready}, 64'd0);
    chk("reset_result", result, 64'd0);
    rst = 1'b0;
    tick();

    do_div(1'b0, 32'd7, 32'd2, 33, 64'h00000001_00000003, "divu_7_2");
    do_div(1'b1, 32'hFFFFFFF9, 32'h00000002, 33, 64'hFFFFFFFF_FFFFFFFD, "div_m7_2");
    do_div(1'b1, 32'h00000007, 32'hFFFFFFFE, 33, 64'h00000001_FFFFFFFD, "div_7_m2");
    do_div(1'b1, 32'h12345678, 32'h00000000, 2, 64'h0, "div_by_zero");
    do_div(1'b1, 32'h80000000, 32'hFFFFFFFF, 33, 64'h00000000_80000000, "div_overflow");

    // Annul mid-operation, then a fresh request two cycles later.
    signed_div = 1'b0;
    op1 = 32'd100;
    op2 = 32'd3;
    start = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      seen |= ready;
    end
    annul = 1'b1;
    tick();
    seen |= ready;
    chk("annul_ready", {63'd0, ready}, 64'd0);
    chk("annul_result", result, 64'd0);
    chk("annul_never_ready", {63'd0, seen}, 64'd0);
    annul = 1'b0;
    start = 1'b0;
    tick();
    do_div(1'b0, 32'd9, 32'd4, 33, 64'h00000001_00000002, "divu_9_4");

    // Reset during ON with start held; the request restarts once reset falls.
    signed_div = 1'b0;
    op1 = 32'd100;
    op2 = 32'd3;
    start = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    rst = 1'b1;
    tick();
    chk("rst_mid_ready", {63'd0, ready}, 64'd0);
    chk("rst_mid_result", result, 64'd0);
    rst = 1'b0;
    do_div(1'b0, 32'd100, 32'd3, 33, 64'h00000001_00000021, "divu_100_3_restart");

    // Dropping start mid-operation aborts without a result.
    signed_div = 1'b0;
    op1 = 32'd7;
    op2 = 32'd2;
    start = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 35; i++) begin
      tick();
      seen |= ready;
    end
    chk("abort_never_ready", {63'd0, seen}, 64'd0);
    chk("abort_result", result, 64'd0);

    do_div(1'b0, 32'd5, 32'd9, SMALL_LAT, 64'h00000005_00000000, "divu_5_9");
    do_div(1'b1, 32'hFFFFFFFB, 32'd9, SMALL_LAT, 64'hFFFFFFFB_00000000, "div_m5_9");
    do_div(1'b0, 32'hFFFFFFFF, 32'd1, 33, 64'h00000000_FFFFFFFF, "divu_max_1");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
